// File: rtl/cpu_defs.sv
// Shared definitions for the cpu1 phase sequencer.
// Phase codes double as the debug display encoding.
package cpu_defs;

  localparam logic [2:0] PH_STOP   = 3'd0;
  localparam logic [2:0] PH_FETCH  = 3'd1;
  localparam logic [2:0] PH_DECODE = 3'd2;
  localparam logic [2:0] PH_EXEC   = 3'd3;
  localparam logic [2:0] PH_MEM    = 3'd4;
  localparam logic [2:0] PH_WB     = 3'd5;
  localparam logic [2:0] PH_HALT   = 3'd6;
  localparam logic [2:0] PH_ERR    = 3'd7;

  localparam int TMO_W_DEF  = 4;
  localparam int ICNT_W_DEF = 32;

  typedef enum logic [2:0] {
    S_STOP   = PH_STOP,
    S_FETCH  = PH_FETCH,
    S_DECODE = PH_DECODE,
    S_EXEC   = PH_EXEC,
    S_MEM    = PH_MEM,
    S_WB     = PH_WB,
    S_HALT   = PH_HALT,
    S_ERR    = PH_ERR
  } state_e;

endpackage

// File: rtl/mem_tmo.sv
// Memory-wait timeout counter: clear/increment with a flag
// raised on the increment that reaches the terminal count.
module mem_tmo #(
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [TMO_W-1:0] ONES = '1;
  localparam logic [TMO_W-1:0] LAST = ONES - TMO_W'(1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  assign tc_o = inc_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Instruction-phase sequencer for cpu1: phase FSM, regm
// load strobes, run/step/halt control and memory timeout.
module cpu_phase_ctrl
  import cpu_defs::*;
#(
  parameter int TMO_W  = TMO_W_DEF,
  parameter int ICNT_W = ICNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              need_mem,
  input  logic              halt_req,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              ir_cen,
  output logic              pc_cen,
  output logic              res_cen,
  output logic              rf_wen,
  output logic [2:0]        phase,
  output logic              halted,
  output logic              bus_err,
  output logic [ICNT_W-1:0] icnt
);

  state_e            state_q;
  state_e            state_d;
  logic              mem_flag_q;
  logic              mem_flag_d;
  logic              step_q;
  logic [ICNT_W-1:0] icnt_q;
  logic [ICNT_W-1:0] icnt_d;

  logic step_edge;
  logic tmo_inc;
  logic tmo_clr;
  logic tmo_tc;
  logic mreq_c;
  logic ir_c;
  logic pc_c;
  logic res_c;
  logic rf_c;

  assign step_edge = step & ~step_q;
  assign tmo_inc   = ((state_q == S_FETCH) || (state_q == S_MEM))
                     && !mem_ready;
  assign tmo_clr   = (state_d != state_q)
                     && ((state_d == S_FETCH) || (state_d == S_MEM));

  mem_tmo #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmo_clr),
    .inc_i (tmo_inc),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d    = state_q;
    mem_flag_d = mem_flag_q;
    icnt_d     = icnt_q;
    mreq_c     = 1'b0;
    ir_c       = 1'b0;
    pc_c       = 1'b0;
    res_c      = 1'b0;
    rf_c       = 1'b0;
    unique case (state_q)
      S_STOP: begin
        if (run || step_edge) state_d = S_FETCH;
      end
      S_FETCH: begin
        mreq_c = 1'b1;
        if (mem_ready) begin
          ir_c    = 1'b1;
          pc_c    = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_tc) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        mem_flag_d = need_mem;
        state_d    = halt_req ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        res_c   = 1'b1;
        state_d = mem_flag_q ? S_MEM : S_WB;
      end
      S_MEM: begin
        mreq_c = 1'b1;
        if (mem_ready) begin
          res_c   = 1'b1;
          state_d = S_WB;
        end else if (tmo_tc) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        rf_c    = 1'b1;
        icnt_d  = icnt_q + ICNT_W'(1);
        state_d = run ? S_FETCH : S_STOP;
      end
      S_HALT: ;
      S_ERR: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_STOP;
      mem_flag_q <= 1'b0;
      step_q     <= 1'b0;
      icnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_flag_q <= mem_flag_d;
      step_q     <= step;
      icnt_q     <= icnt_d;
    end
  end

  // Reset aborts the current phase, so no strobe may leak out
  assign mem_req = mreq_c & ~reset;
  assign ir_cen  = ir_c & ~reset;
  assign pc_cen  = pc_c & ~reset;
  assign res_cen = res_c & ~reset;
  assign rf_wen  = rf_c & ~reset;
  assign halted  = (state_q == S_HALT) & ~reset;
  assign bus_err = (state_q == S_ERR) & ~reset;
  assign phase   = state_q;
  assign icnt    = icnt_q;

endmodule
